sa_encoder: RTL and testbench

Sample-adaptive entropy coder for the CCSDS-123 compressor: converts one mapped prediction residual per cycle into a variable-length Golomb-power-of-two codeword. Sits directly upstream of the bit packer and drives its in_valid/in_last/in_data/in_num_bits inputs one-to-one. It keeps adaptive accumulator/counter statistics across an image, and no backpressure exists on either side.

---
 rtl/sa_encoder.sv | 136 +++++++++++++
 tb/tb_sa_encoder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sa_encoder.sv
// Sample-adaptive Golomb-power-of-two entropy coder: one mapped residual in per cycle,
// one registered variable-length codeword out one cycle later, with adaptive A/C statistics.
module sa_encoder #(
    parameter int D          = 8,
    parameter int UMAX       = 16,
    parameter int GAMMA0     = 1,
    parameter int GAMMA_STAR = 6,
    parameter int K_INIT     = 3
) (
    input  logic                clk,
    input  logic                aresetn,
    input  logic                in_valid,
    input  logic                in_last,
    input  logic [D-1:0]        in_delta,
    output logic                out_valid,
    output logic                out_last,
    output logic [UMAX+D-1:0]   out_data,
    output logic [4:0]          out_num_bits
);

    localparam int CW     = GAMMA_STAR;
    localparam int AW     = D + GAMMA_STAR + 1;
    localparam int OW     = UMAX + D;
    localparam int C_INIT = 2 ** GAMMA0;
    localparam int C_MAX  = 2 ** GAMMA_STAR - 1;
    localparam int A_INIT = ((3 * (2 ** (K_INIT + 6)) - 49) * C_INIT) >> 7;

    // Adaptive statistics and image-position state
    logic          first_q, first_d;
    logic [CW-1:0] c_q, c_d;
    logic [AW-1:0] a_q, a_d;

    // Registered codeword outputs
    logic          out_valid_q, out_valid_d;
    logic          out_last_q, out_last_d;
    logic [OW-1:0] out_data_q, out_data_d;
    logic [4:0]    out_num_bits_q, out_num_bits_d;

    // Combinational coding path
    logic [31:0]   r_sum;
    logic [4:0]    k_sel;
    logic [31:0]   quot;
    logic [OW-1:0] one_k;
    logic [31:0]   acc_sum;

    // k is the largest shift (capped at D-2) such that C*2^k still fits under R;
    // because C*2^k grows monotonically, the last passing shift in the loop wins.
    always_comb begin
        r_sum = 32'(a_q) + ((32'(c_q) * 32'd49) >> 7);
        k_sel = '0;
        for (int i = 1; i <= D - 2; i++) begin
            if ((32'(c_q) << i) <= r_sum) begin
                k_sel = 5'(i);
            end
        end
    end

    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        first_d        = first_q;
        c_d            = c_q;
        a_d            = a_q;
        out_valid_d    = 1'b0;
        out_last_d     = 1'b0;
        out_data_d     = '0;
        out_num_bits_d = '0;

        quot    = 32'(in_delta) >> k_sel;
        one_k   = OW'(1) << k_sel;
        acc_sum = 32'(a_q) + 32'(in_delta);

        if (in_valid) begin
            out_valid_d = 1'b1;
            out_last_d  = in_last;

            if (first_q) begin
                // First sample of an image travels uncoded and leaves the statistics alone
                out_data_d     = OW'(in_delta);
                out_num_bits_d = 5'(D);
                first_d        = 1'b0;
            end else begin
                if (quot < 32'(UMAX)) begin
                    out_data_d     = one_k | (OW'(in_delta) & (one_k - OW'(1)));
                    out_num_bits_d = 5'(quot + 32'(k_sel) + 32'd1);
                end else begin
                    out_data_d     = OW'(in_delta);
                    out_num_bits_d = 5'(OW);
                end

                if (c_q < CW'(C_MAX)) begin
                    a_d = AW'(acc_sum);
                    c_d = c_q + CW'(1);
                end else begin
                    a_d = AW'((acc_sum + 32'd1) >> 1);
                    c_d = CW'((32'(c_q) + 32'd1) >> 1);
                end
            end

            // End of image overrides any update: the next valid sample starts fresh
            if (in_last) begin
                first_d = 1'b1;
                c_d     = CW'(C_INIT);
                a_d     = AW'(A_INIT);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            first_q        <= 1'b1;
            c_q            <= CW'(C_INIT);
            a_q            <= AW'(A_INIT);
            out_valid_q    <= 1'b0;
            out_last_q     <= 1'b0;
            out_data_q     <= '0;
            out_num_bits_q <= '0;
        end else begin
            first_q        <= first_d;
            c_q            <= c_d;
            a_q            <= a_d;
            out_valid_q    <= out_valid_d;
            out_last_q     <= out_last_d;
            out_data_q     <= out_data_d;
            out_num_bits_q <= out_num_bits_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_last     = out_last_q;
    assign out_data     = out_data_q;
    assign out_num_bits = out_num_bits_q;

endmodule

// File: tb/tb_sa_encoder.sv
// Directed and random bench for sa_encoder: a behavioural model pushes expected codewords
// into a scoreboard queue as stimulus is driven; they are popped when the DUT emits output.
module tb_sa_encoder;

    localparam int D          = 8;
    localparam int UMAX       = 16;
    localparam int GAMMA0     = 1;
    localparam int GAMMA_STAR = 6;
    localparam int K_INIT     = 3;
    localparam int OW         = UMAX + D;

    typedef struct packed {
        logic [OW-1:0] data;
        logic [4:0]    nbits;
        logic          last;
    } cw_t;

    logic          clk = 1'b0;
    logic          aresetn = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic [D-1:0]  in_delta = '0;
    logic          out_valid;
    logic          out_last;
    logic [OW-1:0] out_data;
    logic [4:0]    out_num_bits;

    sa_encoder #(
        .D(D), .UMAX(UMAX), .GAMMA0(GAMMA0), .GAMMA_STAR(GAMMA_STAR), .K_INIT(K_INIT)
    ) dut (
        .clk(clk),
        .aresetn(aresetn),
        .in_valid(in_valid),
        .in_last(in_last),
        .in_delta(in_delta),
        .out_valid(out_valid),
        .out_last(out_last),
        .out_data(out_data),
        .out_num_bits(out_num_bits)
    );

    always #5 clk = ~clk;

    cw_t sb[$];
    int  n_assert = 0;
    int  n_fail   = 0;

    // Reference model state
    int  m_first;
    int  m_c;
    int  m_a;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_init();
        m_first = 1;
        m_c     = 2 ** GAMMA0;
        m_a     = ((3 * (2 ** (K_INIT + 6)) - 49) * m_c) / 128;
    endtask

    task automatic model_step(input logic last, input int delta, output cw_t cw);
        int r, k, u;
        cw.last = last;
        if (m_first != 0) begin
            cw.data  = OW'(delta);
            cw.nbits = 5'(D);
            m_first  = 0;
        end else begin
            r = m_a + (49 * m_c) / 128;
            k = 0;
            if (2 * m_c <= r) begin
                k = D - 2;
                while (m_c * (1 << k) > r) k--;
            end
            u = delta / (1 << k);
            if (u < UMAX) begin
                cw.data  = OW'((1 << k) + delta % (1 << k));
                cw.nbits = 5'(u + 1 + k);
            end else begin
                cw.data  = OW'(delta);
                cw.nbits = 5'(UMAX + D);
            end
            if (m_c < 2 ** GAMMA_STAR - 1) begin
                m_a = m_a + delta;
                m_c = m_c + 1;
            end else begin
                m_a = (m_a + delta + 1) / 2;
                m_c = (m_c + 1) / 2;
            end
        end
        if (last) model_init();
    endtask

    // One clock of stimulus; outputs are sampled 1ns after the edge that registers them
    task automatic step(input logic v, input logic l, input int delta);
        cw_t cw;
        cw_t got;
        @(negedge clk);
        in_valid = v;
        in_last  = l;
        in_delta = D'(delta);
        if (v) begin
            model_step(l, delta, cw);
            sb.push_back(cw);
        end
        @(posedge clk);
        #1;
        check("out_valid", 32'(out_valid), 32'(v));
        if (out_valid === 1'b1) begin
            check("sb_depth", 32'(sb.size()), 32'd1);
            if (sb.size() != 0) begin
                got = sb.pop_front();
                check("sb_data", 32'(out_data), 32'(got.data));
                check("sb_nbits", 32'(out_num_bits), 32'(got.nbits));
                check("sb_last", 32'(out_last), 32'(got.last));
            end
        end else begin
            check("idle_data", 32'(out_data), 32'd0);
            check("idle_nbits", 32'(out_num_bits), 32'd0);
            check("idle_last", 32'(out_last), 32'd0);
        end
    endtask

    task automatic expect_cw(input string tag, input int data, input int nbits, input logic last);
        check({tag, "_data"}, 32'(out_data), 32'(data));
        check({tag, "_nbits"}, 32'(out_num_bits), 32'(nbits));
        check({tag, "_last"}, 32'(out_last), 32'(last));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_last"}, 32'(out_last), 32'd0);
        check({tag, "_data"}, 32'(out_data), 32'd0);
        check({tag, "_nbits"}, 32'(out_num_bits), 32'd0);
    endtask

    initial begin
        model_init();

        // Power-on reset, asserted asynchronously
        #1 aresetn = 1'b0;
        #1 check_reset_outputs("por");
        repeat (2) @(posedge clk);
        @(negedge clk);
        aresetn = 1'b1;

        // Image 1: uncoded first sample, then k=3 coding
        step(1, 0, 8'hA5);  expect_cw("first", 8'hA5, 8, 0);
        step(1, 0, 5);      expect_cw("k3_d5", 13, 4, 0);
        step(1, 0, 0);      expect_cw("k3_d0", 8, 4, 0);
        step(1, 1, 9);

        // Image 2: escape codeword on the second sample, then a bubble
        step(1, 0, 8'h10);  expect_cw("first2", 8'h10, 8, 0);
        step(1, 0, 200);    expect_cw("escape", 200, 24, 0);
        step(0, 0, 8'hFF);
        step(1, 1, 2);

        // Image 3: drive C to its limit, then rescale
        step(1, 0, 1);
        for (int i = 0; i < 60; i++) step(1, 0, 0);
        step(1, 0, 0);      expect_cw("c63_zero", 1, 1, 0);
        step(1, 0, 0);
        step(1, 0, 40);     expect_cw("post_rescale", 40, 24, 0);
        step(1, 0, 3);
        step(1, 1, 0);

        // Image 4: out_last only on the third codeword; fourth restarts uncoded
        step(1, 0, 7);      check("l1_last", 32'(out_last), 32'd0);
        step(1, 0, 9);      check("l2_last", 32'(out_last), 32'd0);
        step(1, 1, 3);      check("l3_last", 32'(out_last), 32'd1);
        step(1, 0, 8'h33);  expect_cw("after_last", 8'h33, 8, 0);
        step(0, 1, 8'h44);
        step(1, 1, 6);

        // Single-sample image
        step(1, 1, 8'h77);  expect_cw("single", 8'h77, 8, 1);
        step(1, 0, 8'h12);  expect_cw("single_next", 8'h12, 8, 0);

        // Random traffic with bubbles, rare image ends, and a reset pulse mid-image
        for (int i = 0; i < 400; i++) begin
            logic v, l;
            int   d;
            v = ($urandom_range(0, 3) != 0);
            l = v && ($urandom_range(0, 24) == 0);
            d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 15));
            if (i == 200) begin
                step(1, 0, 8'h21);
                #2;
                aresetn  = 1'b0;
                in_valid = 1'b0;
                in_last  = 1'b0;
                #1 check_reset_outputs("mid_reset");
                model_init();
                sb.delete();
                @(negedge clk);
                aresetn = 1'b1;
                step(1, 0, 8'h5C);  expect_cw("post_reset", 8'h5C, 8, 0);
            end else begin
                step(v, l, d);
            end
        end

        step(0, 0, 0);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
